imem_boot_ctrl: RTL and testbench

Boot/reload controller for the 1024-byte instruction memory. It accepts a program as a byte stream with a valid/ready handshake and drives the memory's byte write port. It holds the pipeline stalled while no complete program is present and releases it with a one-cycle PC-reset pulse once loading finishes. It sits between the off-chip loader interface and both the instruction memory and the fetch stage.

---
 rtl/imem_boot_ctrl.sv | 133 +++++++++++++
 tb/tb_imem_boot_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// Boot/reload controller for the instruction memory: accepts a length-prefixed byte stream,
// writes it through a registered byte port and gates the core until a complete program is present.
module imem_boot_ctrl #(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = 10,
  parameter int LW        = 11
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          load_start_i,
  input  logic [LW-1:0] load_len_i,
  input  logic          load_abort_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_data_i,
  output logic          byte_ready_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_waddr_o,
  output logic [7:0]    mem_wdata_o,
  output logic          core_stall_o,
  output logic          pc_reset_o,
  output logic          load_done_o,
  output logic          load_err_o,
  output logic [LW-1:0] loaded_len_o
);

  typedef enum logic [1:0] {
    HELD    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] cnt_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] loaded_len_q;
  logic          err_q;

  logic          vld_p1;
  logic [AW-1:0] waddr_p1;
  logic [7:0]    wdata_p1;

  logic idle;
  logic len_bad;
  logic len_zero;
  logic start_ok;
  logic hs;
  logic last_hs;

  // True when the byte at cnt is the final one of a len-byte program.
  function automatic logic is_last_byte(input logic [AW-1:0] cnt, input logic [LW-1:0] len);
    return (LW'(cnt) + LW'(1)) == len;
  endfunction

  assign idle     = (state_q == HELD) || (state_q == RUN);
  assign len_bad  = load_len_i > LW'(MEM_BYTES);
  assign len_zero = load_len_i == '0;
  assign start_ok = idle && load_start_i && !len_bad;

  // An abort in the same cycle wins over the byte, so it is never accepted.
  assign hs      = (state_q == LOAD) && byte_valid_i && !load_abort_i;
  assign last_hs = hs && is_last_byte(cnt_q, len_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HELD, RUN: begin
        if (start_ok) begin
          state_d = len_zero ? RELEASE : LOAD;
        end
      end
      LOAD: begin
        if (load_abort_i) begin
          state_d = HELD;
        end else if (last_hs) begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = RUN;
      default: state_d = HELD;
    endcase
  end

  // Stage p0: control state, byte counter and length bookkeeping
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= HELD;
      cnt_q        <= '0;
      len_q        <= '0;
      loaded_len_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= idle && load_start_i && len_bad;
      if (start_ok) begin
        len_q <= load_len_i;
        cnt_q <= '0;
      end else if (hs && !last_hs) begin
        cnt_q <= cnt_q + AW'(1);
      end
      if (state_q == RELEASE) begin
        loaded_len_q <= len_q;
      end
    end
  end

  // Stage p1: registered memory write port; cleared by reset so no in-flight byte survives
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= hs;
      if (hs) begin
        waddr_p1 <= cnt_q;
        wdata_p1 <= byte_data_i;
      end
    end
  end

  assign byte_ready_o = (state_q == LOAD);
  assign core_stall_o = (state_q != RUN);
  assign pc_reset_o   = (state_q == RELEASE);
  assign load_done_o  = (state_q == RELEASE);
  assign load_err_o   = err_q;
  assign loaded_len_o = loaded_len_q;
  assign mem_we_o     = vld_p1;
  assign mem_waddr_o  = waddr_p1;
  assign mem_wdata_o  = wdata_p1;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized bench for imem_boot_ctrl: per-cycle expectations derived from the load protocol
// timing, plus a byte-image scoreboard of what the memory should hold.
module tb_imem_boot_ctrl;

  localparam int MEM_BYTES = 1024;
  localparam int AW        = 10;
  localparam int LW        = 11;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          load_start_i;
  logic [LW-1:0] load_len_i;
  logic          load_abort_i;
  logic          byte_valid_i;
  logic [7:0]    byte_data_i;
  logic          byte_ready_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_waddr_o;
  logic [7:0]    mem_wdata_o;
  logic          core_stall_o;
  logic          pc_reset_o;
  logic          load_done_o;
  logic          load_err_o;
  logic [LW-1:0] loaded_len_o;

  imem_boot_ctrl #(.MEM_BYTES(MEM_BYTES), .AW(AW), .LW(LW)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .load_start_i (load_start_i),
    .load_len_i   (load_len_i),
    .load_abort_i (load_abort_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_waddr_o  (mem_waddr_o),
    .mem_wdata_o  (mem_wdata_o),
    .core_stall_o (core_stall_o),
    .pc_reset_o   (pc_reset_o),
    .load_done_o  (load_done_o),
    .load_err_o   (load_err_o),
    .loaded_len_o (loaded_len_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Expectations for the current cycle (e_) and the next one (n_).
  logic          e_stall, e_ready, e_pulse, e_err, e_we;
  logic [AW-1:0] e_addr;
  logic [7:0]    e_data;
  logic [LW-1:0] e_len;
  logic          n_stall, n_ready, n_pulse, n_err, n_we;
  logic [AW-1:0] n_addr;
  logic [7:0]    n_data;
  logic [LW-1:0] n_len;
  bit            in_run;

  logic [7:0] img_exp [MEM_BYTES];
  logic [7:0] img_dut [MEM_BYTES];
  logic [7:0] pat [4];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("stall", 32'(core_stall_o), 32'(e_stall));
    chk("ready", 32'(byte_ready_o), 32'(e_ready));
    chk("pc_reset", 32'(pc_reset_o), 32'(e_pulse));
    chk("done", 32'(load_done_o), 32'(e_pulse));
    chk("err", 32'(load_err_o), 32'(e_err));
    chk("we", 32'(mem_we_o), 32'(e_we));
    chk("waddr", 32'(mem_waddr_o), 32'(e_addr));
    chk("wdata", 32'(mem_wdata_o), 32'(e_data));
    if (!e_pulse) chk("loaded_len", 32'(loaded_len_o), 32'(e_len));
    if (mem_we_o === 1'b1) img_dut[mem_waddr_o] = mem_wdata_o;
  endtask

  task automatic set_reset_expect();
    e_stall = 1'b1; e_ready = 1'b0; e_pulse = 1'b0; e_err = 1'b0; e_we = 1'b0;
    e_addr = '0; e_data = '0; e_len = '0;
    n_stall = 1'b1; n_ready = 1'b0; n_pulse = 1'b0; n_err = 1'b0; n_we = 1'b0;
    n_addr = '0; n_data = '0; n_len = '0;
    in_run = 1'b0;
  endtask

  // Check the current cycle, cross the next rising edge, promote next-cycle expectations.
  task automatic advance();
    @(negedge clk_i);
    check_outputs();
    @(posedge clk_i);
    #1;
    e_stall = n_stall; e_ready = n_ready; e_pulse = n_pulse; e_err = n_err; e_we = n_we;
    if (n_we) begin
      e_addr = n_addr;
      e_data = n_data;
    end
    e_len = n_len;
    n_pulse = 1'b0; n_err = 1'b0; n_we = 1'b0;
    load_start_i = 1'b0; load_abort_i = 1'b0; byte_valid_i = 1'b0;
    byte_data_i = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      byte_valid_i = 1'($urandom_range(0, 1));
      load_abort_i = 1'($urandom_range(0, 1));
      n_stall = !in_run; n_ready = 1'b0;
      advance();
    end
  endtask

  task automatic reject(input int len);
    load_start_i = 1'b1; load_len_i = LW'(len);
    load_abort_i = 1'($urandom_range(0, 1));
    byte_valid_i = 1'($urandom_range(0, 1));
    n_stall = !in_run; n_ready = 1'b0; n_err = 1'b1;
    advance();
    n_stall = !in_run; n_ready = 1'b0;
    advance();
  endtask

  // Called at posedge+1 of a cycle; ends at posedge+1 of the first cycle after reset.
  task automatic async_reset();
    #1;
    check_outputs();
    byte_valid_i = 1'b1;
    #1;
    rst_n_i = 1'b0;
    #1;
    set_reset_expect();
    check_outputs();
    repeat (2) begin
      @(negedge clk_i);
      chk("we_in_reset", 32'(mem_we_o), 32'd0);
      chk("stall_in_reset", 32'(core_stall_o), 32'd1);
    end
    @(posedge clk_i);
    #3;
    byte_valid_i = 1'b0; load_start_i = 1'b0; load_abort_i = 1'b0;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // cut_at: handshake index at which to abort (cut_rst=0) or hit reset (cut_rst=1); -1 for none.
  task automatic run_load(input int len, input bit gaps, input int cut_at, input bit cut_rst,
                          input bit use_pat);
    int k;
    bit v;
    load_start_i = 1'b1; load_len_i = LW'(len);
    load_abort_i = 1'($urandom_range(0, 1));
    byte_valid_i = 1'($urandom_range(0, 1));
    n_stall = 1'b1; n_ready = (len != 0); n_pulse = (len == 0);
    advance();
    if (len == 0) begin
      n_stall = 1'b0; n_ready = 1'b0; n_len = '0; in_run = 1'b1;
      advance();
      return;
    end
    k = 0;
    forever begin
      if (cut_rst && k == cut_at) begin
        async_reset();
        return;
      end
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_valid_i = v;
      byte_data_i  = use_pat ? pat[k] : 8'($urandom);
      load_start_i = 1'($urandom_range(0, 1));
      load_len_i   = LW'($urandom_range(0, 2047));
      if (!cut_rst && v && k == cut_at) begin
        load_abort_i = 1'b1;
        n_stall = 1'b1; n_ready = 1'b0; in_run = 1'b0;
        advance();
        return;
      end
      n_stall = 1'b1; n_ready = 1'b1;
      if (v) begin
        n_we = 1'b1; n_addr = AW'(k); n_data = byte_data_i;
        img_exp[k] = byte_data_i;
        k++;
      end
      if (v && k == len) begin
        n_ready = 1'b0; n_pulse = 1'b1;
        advance();
        n_stall = 1'b0; n_ready = 1'b0; n_len = LW'(len); in_run = 1'b1;
        advance();
        return;
      end
      advance();
    end
  endtask

  initial begin
    int nbad;
    int r;
    for (int i = 0; i < MEM_BYTES; i++) begin
      img_exp[i] = 8'h00;
      img_dut[i] = 8'h00;
    end
    pat[0] = 8'h30; pat[1] = 8'hF2; pat[2] = 8'h10; pat[3] = 8'h00;
    load_start_i = 1'b0; load_len_i = '0; load_abort_i = 1'b0;
    byte_valid_i = 1'b0; byte_data_i = 8'h00;
    rst_n_i = 1'b1;
    #1;
    rst_n_i = 1'b0;
    #1;
    set_reset_expect();
    check_outputs();
    @(posedge clk_i);
    #3;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    run_load(4, 1'b0, -1, 1'b0, 1'b1);
    idle(3);
    run_load(4, 1'b1, -1, 1'b0, 1'b1);
    idle(2);
    reject(1025);
    reject(2047);
    idle(1);
    run_load(1024, 1'b0, -1, 1'b0, 1'b0);
    idle(2);
    run_load(8, 1'b0, 2, 1'b0, 1'b0);
    idle(2);
    reject(1100);
    run_load(2, 1'b0, -1, 1'b0, 1'b0);
    idle(2);

    repeat (14) begin
      r = $urandom_range(0, 9);
      if (r < 2) reject($urandom_range(1025, 2047));
      else run_load($urandom_range(1, 40), 1'($urandom_range(0, 1)),
                    (r == 2) ? int'($urandom_range(0, 5)) : -1, 1'b0, 1'b0);
      idle($urandom_range(0, 3));
    end

    run_load(8, 1'b0, 3, 1'b1, 1'b0);
    idle(1);
    run_load(0, 1'b0, -1, 1'b0, 1'b0);
    idle(2);

    nbad = 0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      if (img_dut[i] !== img_exp[i]) nbad++;
    end
    chk("image_mismatches", 32'(nbad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
